// File: rtl/a0_cap_pkg.sv
// a0_cap_pkg: shared types and constants for the a0 capture FIFO
package a0_cap_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, TRACK} cap_state_t;
  localparam int DEFAULT_DEPTH = 16;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/a0_fifo_mem.sv
// a0_fifo_mem: show-ahead FIFO storage with wrapping pointers and separate occupancy count
module a0_fifo_mem
  import a0_cap_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  count
);
  localparam int PW = ptr_w(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;
  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];
  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(do_push);
      rptr  <= rptr + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/a0_capture_fifo.sv
// a0_capture_fifo: records changes of cpu a0 into a FIFO drained by valid/ready; A0_TIMESTAMP_EN adds per-entry cycle stamps
module a0_capture_fifo
  import a0_cap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int TS_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [DATA_WIDTH-1:0]    a0_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ptr_w(DEPTH):0]    count_o,
  output logic                     overflow_o,
`ifdef A0_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]      ts_o,
`endif
  input  logic                     clr_ovf_i
);
`ifdef A0_TIMESTAMP_EN
  localparam int EW = DATA_WIDTH + TS_WIDTH;
`else
  localparam int EW = DATA_WIDTH;
`endif
  cap_state_t            state;
  logic [DATA_WIDTH-1:0] prev;
  logic                  push, pop, full, empty;
  logic [EW-1:0]         wdata, rdata;
  assign push    = (state == PRIME) || (state == TRACK && a0_i != prev);
  assign pop     = valid_o && ready_i;
  assign valid_o = !empty;
`ifdef A0_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  assign wdata          = {ts_cnt, a0_i};
  assign {ts_o, data_o} = rdata;
  // free-running cycle counter sampled at each push
  always_ff @(posedge clk) begin
    ts_cnt <= rst ? '0 : ts_cnt + 1'b1;
  end
`else
  assign wdata  = a0_i;
  assign data_o = rdata;
`endif
  // capture FSM: prime records the first value after enable, track records changes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev  <= '0;
    end else begin
      state <= !en_i ? IDLE : (state == IDLE ? PRIME : TRACK);
      if (state != IDLE) prev <= a0_i;
    end
  end
  // sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) overflow_o <= 1'b0;
    else if (push && full && !pop) overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end
  a0_fifo_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );
endmodule

// File: tb/tb_a0_capture_fifo.sv
// tb_a0_capture_fifo: table vectors plus scoreboard checks for a0_capture_fifo
module tb_a0_capture_fifo;
  logic        clk = 0;
  logic        rst = 1;
  logic        en_i = 0;
  logic [31:0] a0_i = 0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 0;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        clr_ovf_i = 0;
`ifdef A0_TIMESTAMP_EN
  logic [15:0] ts_o;
`endif
  int total = 0;
  int bad = 0;
  int          mstate;
  logic [31:0] mprev;
  logic        movf;
  logic [15:0] mts;
  logic [31:0] q[$];
  logic [15:0] tq[$];
  logic [31:0] last_dut;

  a0_capture_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .a0_i       (a0_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
`ifdef A0_TIMESTAMP_EN
    .ts_o       (ts_o),
`endif
    .clr_ovf_i  (clr_ovf_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] a0;
    logic        rdy;
    logic [4:0]  cnt;
    logic        vld;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1; en_i = 0; ready_i = 0; clr_ovf_i = 0;
    @(posedge clk); #1;
    rst = 0;
    q.delete(); tq.delete();
    mstate = 0; mprev = 0; movf = 0; mts = 0;
    chk("rst_count", count_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ovf", overflow_o, 0);
  endtask

  task automatic cyc(input logic en, input logic [31:0] a0, input logic rdy, input logic clr);
    logic mpush;
    logic [31:0] d;
    logic [15:0] t;
    en_i = en; a0_i = a0; ready_i = rdy; clr_ovf_i = clr;
    #1;
    chk("valid", valid_o, q.size() != 0);
    if (q.size() != 0 && rdy) begin
      d = q.pop_front();
      t = tq.pop_front();
      chk("pop_data", data_o, d);
`ifdef A0_TIMESTAMP_EN
      chk("pop_ts", ts_o, t);
`endif
      last_dut = data_o;
    end else if (q.size() == 0) begin
      chk("empty_data", data_o, 0);
`ifdef A0_TIMESTAMP_EN
      chk("empty_ts", ts_o, 0);
`endif
    end
    mpush = (mstate == 1) || (mstate == 2 && a0 != mprev);
    if (mpush && q.size() < 16) begin
      q.push_back(a0);
      tq.push_back(mts);
    end
    if (mpush && q.size() == 16 && q[$] != a0) movf = 1;
    else if (mpush && q.size() == 16 && tq[$] != mts) movf = 1;
    else if (clr) movf = 0;
    if (mstate != 0) mprev = a0;
    mstate = !en ? 0 : (mstate == 0 ? 1 : 2);
    mts = mts + 1;
    @(posedge clk); #1;
    chk("count", count_o, q.size());
    chk("ovf", overflow_o, movf);
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 1, 1, 1};
    tbl[2] = '{1, 1, 1, 0, 0, 0};
    tbl[3] = '{1, 2, 1, 1, 1, 2};
    tbl[4] = '{1, 3, 1, 1, 1, 3};
    tbl[5] = '{1, 3, 1, 0, 0, 0};
    tbl[6] = '{1, 0, 1, 1, 1, 0};
    tbl[7] = '{1, 0, 1, 0, 0, 0};
    #2;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 5, 0, 0);
    chk("t1_count", count_o, 1);
    chk("t1_data", data_o, 5);
    chk("t1_valid", valid_o, 1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].en, tbl[i].a0, tbl[i].rdy, 0);
      chk("tbl_count", count_o, tbl[i].cnt);
      chk("tbl_valid", valid_o, tbl[i].vld);
      chk("tbl_data", data_o, tbl[i].dat);
    end
    do_reset();
    cyc(1, 1000, 0, 0);
    for (int i = 1; i <= 17; i++) cyc(1, i, 0, 0);
    chk("t3_count", count_o, 16);
    chk("t3_ovf", overflow_o, 1);
    chk("t3_head", data_o, 1);
    for (int i = 0; i < 16; i++) cyc(0, 17, 1, 0);
    chk("t3_last", last_dut, 16);
    chk("t3_empty", count_o, 0);
    cyc(0, 17, 0, 1);
    chk("t3_clr", overflow_o, 0);
    do_reset();
    cyc(1, 1000, 0, 0);
    for (int i = 1; i <= 17; i++) cyc(1, i, 0, 0);
    cyc(1, 50, 0, 1);
    chk("setwins_ovf", overflow_o, 1);
    cyc(1, 50, 0, 1);
    chk("clr_ovf", overflow_o, 0);
    do_reset();
    cyc(1, 1000, 0, 0);
    for (int i = 1; i <= 16; i++) cyc(1, i, 0, 0);
    chk("t4_full", count_o, 16);
    cyc(1, 32'hAA, 1, 0);
    chk("t4_count", count_o, 16);
    chk("t4_ovf", overflow_o, 0);
    for (int i = 0; i < 16; i++) cyc(0, 32'hAA, 1, 0);
    chk("t4_last", last_dut, 32'hAA);
    do_reset();
    cyc(1, 1000, 0, 0);
    for (int i = 1; i <= 7; i++) cyc(1, i, 0, 0);
    chk("t5_pre", count_o, 7);
    do_reset();
    cyc(1, 9, 0, 0);
    cyc(1, 9, 0, 0);
    chk("t5_data", data_o, 9);
    chk("t5_count", count_o, 1);
`ifdef A0_TIMESTAMP_EN
    do_reset();
    cyc(0, 7, 0, 0);
    cyc(0, 7, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 0);
    chk("t6_ts1", ts_o, 3);
    for (int i = 0; i < 4; i++) cyc(1, 7, 0, 0);
    cyc(1, 8, 0, 0);
    chk("t6_hold", ts_o, 3);
    cyc(1, 8, 1, 0);
    chk("t6_ts2", ts_o, 8);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
